// File: rtl/hrm_pkg.sv
// Shared definitions for the program fetch unit: opcode nibbles, operand
// decode and fetch FSM state encoding.
package hrm_pkg;

  typedef enum logic [1:0] {
    StIssueOp,
    StLatchOp,
    StLatchArg,
    StPresent
  } fetch_state_e;

  localparam logic [3:0] OpInbox    = 4'h0;
  localparam logic [3:0] OpOutbox   = 4'h1;
  localparam logic [3:0] OpCopyFrom = 4'h2;
  localparam logic [3:0] OpCopyTo   = 4'h3;
  localparam logic [3:0] OpAdd      = 4'h4;
  localparam logic [3:0] OpSub      = 4'h5;
  localparam logic [3:0] OpBumpUp   = 4'h6;
  localparam logic [3:0] OpBumpDn   = 4'h7;
  localparam logic [3:0] OpJump     = 4'h8;
  localparam logic [3:0] OpJumpZ    = 4'h9;
  localparam logic [3:0] OpJumpN    = 4'hA;
  localparam logic [3:0] OpHalt     = 4'hF;

  // Everything from COPYFROM through JUMPN carries a second (operand) byte.
  function automatic logic has_operand(input logic [7:0] opcode);
    return (opcode[7:4] >= OpCopyFrom) && (opcode[7:4] <= OpJumpN);
  endfunction

endpackage

// File: rtl/prog_fetch.sv
// Instruction fetch: reads one- or two-byte instructions from a registered
// program ROM and presents them to the control unit with a valid/ready handshake.
module prog_fetch
  import hrm_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              en,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_instr,
  output logic [7:0]        out_operand,
  output logic [ADDR_W-1:0] out_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic              valid_q, valid_d;
  logic [7:0]        instr_q, instr_d;
  logic [7:0]        operand_q, operand_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opc_d     = opc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    operand_d = operand_q;

    case (state_q)
      StIssueOp: begin
        if (en) begin
          opc_d   = pc_q;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StLatchOp;
        end
      end
      StLatchOp: begin
        instr_d = rom_data;
        if (has_operand(rom_data)) begin
          // rom_addr already points at the operand byte this cycle.
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StLatchArg;
        end else begin
          operand_d = '0;
          valid_d   = 1'b1;
          state_d   = StPresent;
        end
      end
      StLatchArg: begin
        operand_d = rom_data;
        valid_d   = 1'b1;
        state_d   = StPresent;
      end
      StPresent: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIssueOp;
        end
      end
      default: state_d = StIssueOp;
    endcase

    // A redirect overrides everything, including a handshake in the same cycle.
    if (jmp_valid) begin
      pc_d    = jmp_addr;
      valid_d = 1'b0;
      state_d = StIssueOp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIssueOp;
      pc_q      <= RESET_PC;
      opc_q     <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opc_q     <= opc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
    end
  end

  assign rom_addr    = pc_q;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_operand = operand_q;
  assign out_pc      = opc_q;

endmodule

// File: tb/tb_prog_fetch.sv
// Scoreboard bench for prog_fetch: a program-walk model fills an expectation
// queue, a negedge monitor checks every presented instruction against it.
module tb_prog_fetch;

  localparam int unsigned       AW  = 8;
  localparam logic [AW-1:0]     RPC = 8'h00;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] instr;
    logic [7:0] operand;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data = 8'h00;
  logic          en = 1'b0;
  logic          jmp_valid = 1'b0;
  logic [AW-1:0] jmp_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_instr;
  logic [7:0]    out_operand;
  logic [AW-1:0] out_pc;

  logic [7:0]    rom [256];
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [7:0]    model_pc;
  int            n_cmp  = 0;
  int            n_err  = 0;
  int            popped = 0;

  prog_fetch #(
    .ADDR_W  (AW),
    .RESET_PC(RPC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .en         (en),
    .jmp_valid  (jmp_valid),
    .jmp_addr   (jmp_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_operand(out_operand),
    .out_pc     (out_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic bit takes_operand(input logic [7:0] op);
    int hi;
    hi = int'(op) / 16;
    return (hi >= 2) && (hi <= 10);
  endfunction

  // Walk the program from start, queueing n instructions; model_pc ends on the next fetch.
  task automatic push_prog(input logic [7:0] start, input int n);
    logic [7:0] p;
    exp_t       e;
    p = start;
    for (int i = 0; i < n; i++) begin
      e.pc    = p;
      e.instr = rom[p];
      p       = p + 8'd1;
      if (takes_operand(e.instr)) begin
        e.operand = rom[p];
        p         = p + 8'd1;
      end else begin
        e.operand = 8'h00;
      end
      exp_q.push_back(e);
    end
    model_pc = p;
  endtask

  // Monitor: every presented cycle is compared with the head of the queue.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: actual pc %0h instr %0h, required no output",
                 out_pc, out_instr);
      end else begin
        check("out_pc", out_pc, exp_q[0].pc);
        check("out_instr", out_instr, exp_q[0].instr);
        check("out_operand", out_operand, exp_q[0].operand);
        if (out_ready) mon_e = exp_q.pop_front();
      end
      if (out_ready) popped++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random en/ready/jump traffic until n more instructions have been consumed.
  task automatic run_phase(input int n, input int jpct, input int epct, input int rpct);
    int         target;
    int         cyc;
    bit         jumped;
    logic [7:0] jt;
    target = popped + n;
    cyc    = 0;
    jumped = 1'b0;
    jt     = 8'h00;
    while (popped < target && cyc < 4000) begin
      if (jumped) begin
        jmp_valid = 1'b0;
        jumped    = 1'b0;
        exp_q.delete();
        push_prog(jt, target - popped);
      end
      en        = ($urandom_range(99) < epct);
      out_ready = ($urandom_range(99) < rpct);
      if ($urandom_range(99) < jpct) begin
        jt        = 8'($urandom);
        jmp_addr  = jt;
        jmp_valid = 1'b1;
        jumped    = 1'b1;
      end
      tick();
      cyc++;
    end
    if (jumped) begin
      jmp_valid = 1'b0;
      exp_q.delete();
      push_prog(jt, target - popped);
    end
    en        = 1'b0;
    out_ready = 1'b0;
    check("phase_complete", 8'(popped >= target), 8'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h10;
    rom[0] = 8'h00;
    rom[1] = 8'h20;
    rom[2] = 8'h05;
    rom[3] = 8'h45;
    rom[4] = 8'h99;
    model_pc = RPC;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_rom_addr", rom_addr, RPC);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_instr", out_instr, 8'h00);
    check("rst_out_operand", out_operand, 8'h00);
    check("rst_out_pc", out_pc, 8'h00);

    // INBOX then COPYFROM 05: latency 2 and 3 cycles
    push_prog(RPC, 2);
    rst_n     = 1'b1;
    en        = 1'b1;
    out_ready = 1'b1;
    tick();
    check("lat1_valid_c1", 8'(out_valid), 8'd0);
    tick();
    check("lat1_valid_c2", 8'(out_valid), 8'd1);
    tick();
    check("lat2_valid_issue", 8'(out_valid), 8'd0);
    check("lat2_rom_addr_issue", rom_addr, 8'h01);
    tick();
    check("lat2_rom_addr_operand", rom_addr, 8'h02);
    tick();
    check("lat2_valid_c2", 8'(out_valid), 8'd0);
    tick();
    check("lat2_valid_c3", 8'(out_valid), 8'd1);
    en = 1'b0;
    tick();
    check("lat_popped", 8'(popped), 8'd2);

    // Stall in PRESENT for 10 cycles
    push_prog(model_pc, 1);
    out_ready = 1'b0;
    en        = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 8 && !out_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", 8'(out_valid), 8'd1);
      check("stall_rom_addr", rom_addr, model_pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_popped", 8'(popped), 8'd3);

    // Two-byte opcode at FF, operand wraps to 00
    rom[8'hFF] = 8'h80;
    rom[8'h00] = 8'h3C;
    jmp_addr   = 8'hFF;
    jmp_valid  = 1'b1;
    tick();
    jmp_valid = 1'b0;
    push_prog(8'hFF, 2);
    run_phase(2, 0, 100, 100);

    // Jump during LATCH_ARG discards the in-flight instruction
    rom[8'h10] = 8'h1F;
    en         = 1'b1;
    out_ready  = 1'b1;
    tick();
    tick();
    jmp_addr  = 8'h10;
    jmp_valid = 1'b1;
    tick();
    jmp_valid = 1'b0;
    en        = 1'b0;
    check("jmp_valid_after", 8'(out_valid), 8'd0);
    check("jmp_rom_addr", rom_addr, 8'h10);
    tick();
    check("jmp_valid_after2", 8'(out_valid), 8'd0);
    push_prog(8'h10, 1);
    run_phase(1, 0, 100, 100);

    // Asynchronous reset in LATCH_OP
    rom[8'h11] = 8'h77;
    en         = 1'b1;
    tick();
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 8'(out_valid), 8'd0);
    check("arst_out_instr", out_instr, 8'h00);
    check("arst_out_operand", out_operand, 8'h00);
    check("arst_out_pc", out_pc, 8'h00);
    check("arst_rom_addr", rom_addr, RPC);
    exp_q.delete();
    model_pc = RPC;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_rom_addr", rom_addr, RPC);
      check("idle_out_valid", 8'(out_valid), 8'd0);
    end

    // Random program, random enable/ready/jumps
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    push_prog(model_pc, 40);
    run_phase(40, 4, 70, 60);
    push_prog(model_pc, 40);
    run_phase(40, 12, 90, 80);

    tick();
    tick();
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
